// File: rtl/reg_file_pkg.sv
// Shared definitions for the 4x32 control register file and its access arbiter.
package reg_file_pkg;

    localparam logic [31:0] REG_ADDR_0 = 32'h00;
    localparam logic [31:0] REG_ADDR_1 = 32'h04;
    localparam logic [31:0] REG_ADDR_2 = 32'h08;
    localparam logic [31:0] REG_ADDR_3 = 32'h0C;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    // Callers zero-extend their byte address to 32 bits.
    function automatic logic addr_is_legal(input logic [31:0] addr);
        return (addr == REG_ADDR_0) || (addr == REG_ADDR_1) ||
               (addr == REG_ADDR_2) || (addr == REG_ADDR_3);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Upper segment [ptr, NREQ) first; the second pass only fires on wrap.
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && req_i[k] && (k >= int'(ptr_i))) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Serialises NREQ requesters onto the single-port register file: accept, one
// access cycle, then hold the response until the granted requester takes it.
module reg_file_arbiter
    import reg_file_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               rf_we,
    output logic               rf_re,
    output logic [AW-1:0]      rf_addr,
    output logic [DW-1:0]      rf_wdata,
    input  logic [DW-1:0]      rf_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, gnt_q;
    logic            write_q, err_q, rsp_err_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q, rdata_q;

    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            win_write;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_oh[k]) begin
                win_write = req_write[k];
                win_addr  = req_addr[k*AW +: AW];
                win_wdata = req_wdata[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        rf_we     = 1'b0;
        rf_re     = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        case (state_q)
            IDLE: begin
                req_ready = win_oh;
                if (win_any) state_d = ISSUE;
            end
            ISSUE: begin
                rf_we    = write_q & ~err_q;
                rf_re    = ~write_q & ~err_q;
                rf_addr  = addr_q;
                rf_wdata = wdata_q;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset wins over an in-flight access so an aborted write never lands.
        if (!rst_n) begin
            req_ready = '0;
            rsp_valid = '0;
            rf_we     = 1'b0;
            rf_re     = 1'b0;
            rf_addr   = '0;
            rf_wdata  = '0;
        end
    end

    assign rsp_rdata = rst_n ? rdata_q : '0;
    assign rsp_err   = rst_n & rsp_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_any) begin
                gnt_q   <= win_idx;
                write_q <= win_write;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                err_q   <= ~addr_is_legal(32'(win_addr));
            end
            if (state_q == ISSUE) begin
                rdata_q   <= (!write_q && !err_q) ? rf_rdata : '0;
                rsp_err_q <= err_q;
                ptr_q     <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scenario bench for reg_file_arbiter with a behavioural register file and a response scoreboard.
module tb_reg_file_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0, req_write = '0, rsp_ready = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]      rsp_rdata, rf_wdata, rf_rdata;
    logic               rsp_err, rf_we, rf_re;
    logic [AW-1:0]      rf_addr;

    typedef struct {
        int          r;
        logic [DW-1:0] d;
        logic        e;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_regs [4];
    logic [DW-1:0] rf_mem   [4];
    int            checks = 0, errors = 0;
    int            we_cnt = 0, re_cnt = 0;
    logic [AW-1:0] last_we_addr = '0, last_re_addr = '0;
    logic [DW-1:0] last_we_data = '0;

    reg_file_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rf_we(rf_we), .rf_re(rf_re), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf_re ? rf_mem[rf_addr[3:2]] : '0;

    always @(posedge clk) begin
        if (rf_we === 1'b1) begin
            rf_mem[rf_addr[3:2]] <= rf_wdata;
            we_cnt       <= we_cnt + 1;
            last_we_addr <= rf_addr;
            last_we_data <= rf_wdata;
        end
        if (rf_re === 1'b1) begin
            re_cnt       <= re_cnt + 1;
            last_re_addr <= rf_addr;
        end
    end

    function automatic bit legal(input logic [AW-1:0] a);
        return a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C;
    endfunction

    // Waits for any grant, records the expected response from the granted fields.
    task automatic accept_any(output int w, output int lat);
        exp_t e;
        logic [AW-1:0] a;
        w = -1;
        lat = 0;
        forever begin
            @(negedge clk);
            if (|req_ready) break;
            lat++;
            if (lat > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout req_ready=%b required a grant", req_ready);
                return;
            end
        end
        checks++;
        if (!$onehot(req_ready)) begin
            errors++;
            $display("FAIL ready_onehot req_ready=%b required one-hot", req_ready);
        end
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) w = k;
        a = req_addr[w*AW +: AW];
        e.r = w;
        if (!legal(a)) begin
            e.d = '0; e.e = 1'b1;
        end else if (req_write[w]) begin
            e.d = '0; e.e = 1'b0;
            exp_regs[a[3:2]] = req_wdata[w*DW +: DW];
        end else begin
            e.d = exp_regs[a[3:2]]; e.e = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic issue(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w, lat;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = d;
        accept_any(w, lat);
        req_valid[r] = 1'b0;
        checks++;
        if (w != r) begin
            errors++;
            $display("FAIL issue_grant got=%0d exp=%0d", w, r);
        end
    endtask

    // Pops the scoreboard on the next response, optionally backpressuring it.
    task automatic get_rsp(input int hold, output int lat);
        exp_t e;
        logic [NREQ-1:0] oh;
        lat = 0;
        forever begin
            @(negedge clk);
            if (|rsp_valid) break;
            lat++;
            if (lat > 50) begin
                checks++; errors++;
                $display("FAIL rsp_timeout rsp_valid=%b required a response", rsp_valid);
                return;
            end
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected rsp_valid=%b with empty scoreboard", rsp_valid);
            return;
        end
        e  = sb.pop_front();
        oh = NREQ'(1) << e.r;
        if (rsp_valid !== oh) begin
            errors++; $display("FAIL rsp_valid got=%b exp=%b", rsp_valid, oh);
        end
        checks++;
        if (rsp_rdata !== e.d) begin
            errors++; $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, e.d);
        end
        checks++;
        if (rsp_err !== e.e) begin
            errors++; $display("FAIL rsp_err got=%b exp=%b", rsp_err, e.e);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== oh || rsp_rdata !== e.d || req_ready !== '0) begin
                errors++;
                $display("FAIL rsp_hold cyc=%0d valid=%b rdata=%h ready=%b exp valid=%b rdata=%h ready=00",
                         k, rsp_valid, rsp_rdata, req_ready, oh, e.d);
            end
        end
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rf_we, rf_re, rf_addr, rf_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b valid=%b rdata=%h err=%b we=%b re=%b addr=%h wdata=%h exp all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, rf_we, rf_re, rf_addr, rf_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        int lat;
        issue(0, 1, 8'h00, 32'h1111_1111); get_rsp(0, lat);
        issue(0, 1, 8'h04, 32'h2222_2222); get_rsp(0, lat);
        issue(0, 1, 8'h08, 32'h3333_3333); get_rsp(0, lat);
        issue(0, 1, 8'h0C, 32'h1234_5678); get_rsp(0, lat);
    endtask

    task automatic test_write_read();
        int lat, we0, re0;
        we0 = we_cnt;
        issue(0, 1, 8'h08, 32'hDEAD_BEEF);
        get_rsp(0, lat);
        checks++;
        if (we_cnt - we0 != 1 || last_we_addr !== 8'h08 || last_we_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_strobe pulses=%0d addr=%h data=%h exp 1/08/deadbeef",
                     we_cnt - we0, last_we_addr, last_we_data);
        end
        re0 = re_cnt;
        issue(0, 0, 8'h08, '0);
        get_rsp(0, lat);
        checks++;
        if (lat != 1) begin
            errors++; $display("FAIL read_latency got=%0d exp=1 cycle after issue", lat);
        end
        checks++;
        if (re_cnt - re0 != 1) begin
            errors++; $display("FAIL read_strobe pulses=%0d exp=1", re_cnt - re0);
        end
    endtask

    task automatic test_illegal();
        int lat, we0, re0;
        we0 = we_cnt;
        re0 = re_cnt;
        issue(1, 0, 8'h10, '0);
        get_rsp(0, lat);
        issue(1, 1, 8'h05, 32'hFFFF_0000);
        get_rsp(0, lat);
        checks++;
        if (we_cnt != we0 || re_cnt != re0) begin
            errors++;
            $display("FAIL illegal_strobes we=%0d re=%0d exp 0/0", we_cnt - we0, re_cnt - re0);
        end
        issue(1, 0, 8'h04, '0);
        get_rsp(0, lat);
    endtask

    task automatic test_backpressure();
        int lat, w;
        issue(0, 0, 8'h0C, '0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0 +: AW] = 8'h00;
        get_rsp(5, lat);
        accept_any(w, lat);
        req_valid[0] = 1'b0;
        checks++;
        if (w != 0 || lat != 0) begin
            errors++; $display("FAIL resume_accept req=%0d wait=%0d exp 0/0", w, lat);
        end
        get_rsp(0, lat);
    endtask

    task automatic test_reset_mid_op();
        int n, we0;
        n = 0;
        we0 = we_cnt;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0 +: AW]  = 8'h00;
        req_wdata[0 +: DW] = 32'hA5A5_A5A5;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 50);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL abort_we got=%b exp=0", rf_we);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rf_we, rf_re, rf_addr, rf_wdata} !== '0
            || we_cnt != we0) begin
            errors++;
            $display("FAIL abort_outputs valid=%b we=%b addr=%h wpulses=%0d exp all 0",
                     rsp_valid, rf_we, rf_addr, we_cnt - we0);
        end
    endtask

    // Entered with reset held; both requesters hold valid across its release.
    task automatic test_contention();
        int w, lat;
        int order [4] = '{0, 1, 0, 1};
        req_write = '0;
        req_addr[0 +: AW]  = 8'h00;
        req_addr[AW +: AW] = 8'h04;
        req_valid = '1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept_any(w, lat);
            checks++;
            if (w != order[i] || lat > 0) begin
                errors++; $display("FAIL rr_order idx=%0d got=%0d wait=%0d exp=%0d/0", i, w, lat, order[i]);
            end
            get_rsp(0, lat);
        end
        req_valid = '0;
    endtask

    task automatic test_field_change();
        int lat;
        issue(0, 0, 8'h04, '0);
        req_addr[0 +: AW] = 8'h08;
        get_rsp(0, lat);
        checks++;
        if (last_re_addr !== 8'h04) begin
            errors++; $display("FAIL field_change rf_addr got=%h exp=04", last_re_addr);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_illegal();
        test_backpressure();
        test_reset_mid_op();
        test_contention();
        test_field_change();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired exp completion");
        $fatal(1);
    end

endmodule
